// File: rtl/nabp_pkg.sv
// Shared constants, FSM state encoding and Q1.8 angle tables for the NABP engine.
package nabp_pkg;

  localparam int DATA_W    = 8;
  localparam int N_ANG     = 8;
  localparam int N_PROJ    = 16;
  localparam int IMG       = 8;
  localparam int COEF_W    = 10;
  localparam int DOT_W     = 16;

  localparam int ANG_W     = $clog2(N_ANG);
  localparam int PROJ_W    = $clog2(N_PROJ);
  localparam int IMG_W     = $clog2(IMG);
  localparam int SG_ADDR_W = ANG_W + PROJ_W;
  localparam int IR_ADDR_W = 2 * IMG_W;
  localparam int ACC_W     = DATA_W + ANG_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ADDR,
    ST_WAIT,
    ST_ACC,
    ST_DONE,
    ST_READ,
    ST_RDONE
  } state_t;

  // round(256*cos/sin(k*180/N_ANG deg)), k = 0..N_ANG-1
  localparam logic signed [COEF_W-1:0] COS_TAB [N_ANG] = '{
    10'sd256, 10'sd237, 10'sd181, 10'sd98, 10'sd0, -10'sd98, -10'sd181, -10'sd237
  };
  localparam logic signed [COEF_W-1:0] SIN_TAB [N_ANG] = '{
    10'sd0, 10'sd98, 10'sd181, 10'sd237, 10'sd256, 10'sd237, 10'sd181, 10'sd98
  };

endpackage

// File: rtl/nabp_if.sv
// Sinogram-read and image-readout signal bundle between the NABP engine and its host.
interface nabp_if;
  import nabp_pkg::*;

  logic                 sg_kick;
  logic [DATA_W-1:0]    sg_val;
  logic                 ir_kick;
  logic                 ir_enable;
  logic                 sg_done;
  logic [SG_ADDR_W-1:0] sg_addr;
  logic                 ir_kick_ack;
  logic                 ir_done;
  logic [IR_ADDR_W-1:0] ir_addr;
  logic [ACC_W-1:0]     ir_val;

  modport slave (
    input  sg_kick, sg_val, ir_kick, ir_enable,
    output sg_done, sg_addr, ir_kick_ack, ir_done, ir_addr, ir_val
  );

  modport master (
    output sg_kick, sg_val, ir_kick, ir_enable,
    input  sg_done, sg_addr, ir_kick_ack, ir_done, ir_addr, ir_val
  );

endinterface

// File: rtl/nabp_angle_lut.sv
// Combinational projection-angle lookup: angle index -> signed Q1.8 cos/sin.
module nabp_angle_lut
  import nabp_pkg::*;
(
  input  logic [ANG_W-1:0]         ang,
  output logic signed [COEF_W-1:0] cos_q,
  output logic signed [COEF_W-1:0] sin_q
);

  always_comb begin
    cos_q = COS_TAB[ang];
    sin_q = SIN_TAB[ang];
  end

endmodule

// File: rtl/nabp_top.sv
// NABP engine: clears and accumulates an IMG x IMG backprojection from an external sinogram LUT,
// then streams the image to a host one pixel per enabled cycle.
module nabp_top
  import nabp_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  nabp_if.slave  bus
);

  localparam int NPIX = IMG * IMG;
  localparam logic [IR_ADDR_W-1:0] LAST_PIX = IR_ADDR_W'(NPIX - 1);
  localparam logic [ANG_W-1:0]     LAST_ANG = ANG_W'(N_ANG - 1);

  localparam logic signed [DOT_W-1:0] HALF_IMG  = DOT_W'(IMG / 2);
  localparam logic signed [DOT_W-1:0] HALF_PROJ = DOT_W'(N_PROJ / 2);
  localparam logic signed [DOT_W-1:0] N_PROJ_S  = DOT_W'(N_PROJ);
  localparam logic signed [DOT_W-1:0] Q8_HALF   = DOT_W'(128);

  state_t state, state_nxt;

  logic [IR_ADDR_W-1:0] pix;
  logic [ANG_W-1:0]     ang;
  logic [ACC_W-1:0]     acc [NPIX];

  logic signed [COEF_W-1:0] cos_q, sin_q;
  logic signed [DOT_W-1:0]  xs, ys, cs, ss, dot, bin;
  logic                     bin_ok;

  logic [SG_ADDR_W-1:0] sg_addr_p1;
  logic                 oob_p1;

  logic                 sg_done_q, ir_kick_ack_q, ir_done_q;
  logic [IR_ADDR_W-1:0] ir_addr_q;
  logic [ACC_W-1:0]     ir_val_q;

  // Round-half-up of a Q.8 value to an integer (arithmetic shift floors).
  function automatic logic signed [DOT_W-1:0] round_q8(input logic signed [DOT_W-1:0] v);
    logic signed [DOT_W-1:0] t;
    t = v + Q8_HALF;
    return t >>> 8;
  endfunction

  nabp_angle_lut u_angle_lut (
    .ang   (ang),
    .cos_q (cos_q),
    .sin_q (sin_q)
  );

  // Stage p0: detector bin for the current (angle, pixel), centred on the image and the detector
  always_comb begin
    xs     = $signed(DOT_W'(pix[IMG_W-1:0])) - HALF_IMG;
    ys     = $signed(DOT_W'(pix[IR_ADDR_W-1:IMG_W])) - HALF_IMG;
    cs     = DOT_W'(cos_q);
    ss     = DOT_W'(sin_q);
    dot    = xs * cs + ys * ss;
    bin    = round_q8(dot) + HALF_PROJ;
    bin_ok = !bin[DOT_W-1] && (bin < N_PROJ_S);
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.sg_kick)      state_nxt = ST_CLEAR;
        else if (bus.ir_kick) state_nxt = ST_READ;
      end
      ST_CLEAR: if (pix == LAST_PIX) state_nxt = ST_ADDR;
      ST_ADDR:  state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_ACC;
      ST_ACC: begin
        if (pix == LAST_PIX && ang == LAST_ANG) state_nxt = ST_DONE;
        else                                    state_nxt = ST_ADDR;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      ST_READ:  if (bus.ir_enable && pix == LAST_PIX) state_nxt = ST_RDONE;
      ST_RDONE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // pix doubles as clear index, backprojection pixel and readout index; it wraps to 0 between phases
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      pix <= '0;
      ang <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          pix <= '0;
          ang <= '0;
        end
        ST_CLEAR: pix <= pix + 1'b1;
        ST_ACC: begin
          pix <= pix + 1'b1;
          if (pix == LAST_PIX) ang <= ang + 1'b1;
        end
        ST_READ: if (bus.ir_enable) pix <= pix + 1'b1;
        default: ;
      endcase
    end
  end

  // Stage p1: LUT address registered in ADDR; an out-of-range bin leaves sg_addr unchanged
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      sg_addr_p1 <= '0;
      oob_p1     <= 1'b0;
    end else if (state == ST_ADDR) begin
      oob_p1 <= !bin_ok;
      if (bin_ok) sg_addr_p1 <= {ang, bin[PROJ_W-1:0]};
    end
  end

  // Stage p2: sg_val arrives in ACC, one cycle after the LUT sampled sg_addr during WAIT
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      for (int i = 0; i < NPIX; i++) acc[i] <= '0;
    end else begin
      case (state)
        ST_CLEAR: acc[pix] <= '0;
        ST_ACC:   if (!oob_p1) acc[pix] <= acc[pix] + ACC_W'(bus.sg_val);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      sg_done_q     <= 1'b0;
      ir_kick_ack_q <= 1'b0;
      ir_done_q     <= 1'b0;
      ir_addr_q     <= '0;
      ir_val_q      <= '0;
    end else begin
      sg_done_q     <= (state_nxt == ST_DONE);
      ir_kick_ack_q <= (state == ST_IDLE) && (state_nxt == ST_READ);
      ir_done_q     <= (state == ST_RDONE);
      if (state == ST_READ && bus.ir_enable) begin
        ir_addr_q <= pix;
        ir_val_q  <= acc[pix];
      end
    end
  end

  assign bus.sg_done     = sg_done_q;
  assign bus.sg_addr     = sg_addr_p1;
  assign bus.ir_kick_ack = ir_kick_ack_q;
  assign bus.ir_done     = ir_done_q;
  assign bus.ir_addr     = ir_addr_q;
  assign bus.ir_val      = ir_val_q;

endmodule

// File: tb/tb_nabp_top.sv
// Directed bench for nabp_top with a registered-read sinogram LUT model.
module tb_nabp_top;
  import nabp_pkg::*;

  localparam int NPIX = IMG * IMG;
  localparam int LAT  = 1 + NPIX + 3 * N_ANG * NPIX;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  nabp_if bus ();

  nabp_top dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [DATA_W-1:0] mem [1 << SG_ADDR_W];
  always @(posedge clk) bus.sg_val <= mem[bus.sg_addr];

  int tests = 0;
  int fails = 0;
  logic [ACC_W-1:0] rd [NPIX];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_bp(input bit busy_kicks, output int lat);
    int n;
    bus.sg_kick = 1'b1;
    step();
    bus.sg_kick = 1'b0;
    n = 1;
    while (bus.sg_done !== 1'b1 && n < 4000) begin
      if (busy_kicks && n == 100) begin
        bus.sg_kick = 1'b1;
        bus.ir_kick = 1'b1;
      end
      step();
      n++;
      if (busy_kicks && n == 101) begin
        chk("busy_ir_kick_ack", bus.ir_kick_ack, 0);
        bus.sg_kick = 1'b0;
        bus.ir_kick = 1'b0;
      end
    end
    lat = n;
    step();
    chk("sg_done_width", bus.sg_done, 0);
  endtask

  task automatic read_image();
    int bad, extra;
    bad = 0;
    extra = 0;
    bus.ir_kick = 1'b1;
    step();
    bus.ir_kick = 1'b0;
    chk("ir_kick_ack", bus.ir_kick_ack, 1);
    bus.ir_enable = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      step();
      if (bus.ir_addr !== IR_ADDR_W'(i)) bad++;
      if (bus.ir_done !== 1'b0 || bus.sg_done !== 1'b0) extra++;
      rd[i] = bus.ir_val;
    end
    step();
    bus.ir_enable = 1'b0;
    chk("ir_addr_seq", bad, 0);
    chk("no_stray_done", extra, 0);
    chk("ir_done", bus.ir_done, 1);
    step();
    chk("ir_done_width", bus.ir_done, 0);
  endtask

  initial begin
    int lat, bad, cnt, guard, pulses;
    bit en;

    bus.sg_kick = 1'b0;
    bus.ir_kick = 1'b0;
    bus.ir_enable = 1'b0;
    for (int a = 0; a < (1 << SG_ADDR_W); a++) mem[a] = 8'd1;

    repeat (3) step();
    chk("rst_sg_done", bus.sg_done, 0);
    chk("rst_sg_addr", bus.sg_addr, 0);
    chk("rst_ir_kick_ack", bus.ir_kick_ack, 0);
    chk("rst_ir_done", bus.ir_done, 0);
    chk("rst_ir_addr", bus.ir_addr, 0);
    chk("rst_ir_val", bus.ir_val, 0);
    reset_n = 1'b0;
    step();

    // all-ones sinogram: every pixel collects one count per angle
    run_bp(1'b0, lat);
    chk("t1_latency", lat, LAT);
    read_image();
    chk("t1_pix_4_4", rd[36], 8);
    chk("t1_pix_0_0", rd[0], 8);
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (rd[i] !== 11'd8) bad++;
    chk("t1_all_pixels", bad, 0);

    // second run with no reset, plus kicks while busy
    run_bp(1'b1, lat);
    chk("t3_latency", lat, LAT);
    read_image();
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (rd[i] !== 11'd8) bad++;
    chk("t3_not_doubled", bad, 0);

    // single nonzero sample at angle 0, bin 8 lights the x=4 column
    for (int a = 0; a < (1 << SG_ADDR_W); a++) mem[a] = 8'd0;
    mem[8] = 8'd100;
    run_bp(1'b0, lat);
    chk("t2_latency", lat, LAT);
    read_image();
    chk("t2_pix_4_0", rd[4], 100);
    chk("t2_pix_0_0", rd[0], 0);
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (rd[i] !== (((i % IMG) == 4) ? 11'd100 : 11'd0)) bad++;
    chk("t2_column", bad, 0);

    // readout with ir_enable toggling
    bus.ir_kick = 1'b1;
    step();
    bus.ir_kick = 1'b0;
    chk("t5_ir_kick_ack", bus.ir_kick_ack, 1);
    cnt = 0;
    bad = 0;
    guard = 0;
    while (cnt < NPIX && guard < 400) begin
      en = ((guard % 3) != 1);
      bus.ir_enable = en;
      step();
      guard++;
      if (en) begin
        if (bus.ir_addr !== IR_ADDR_W'(cnt)) bad++;
        if (bus.ir_val !== (((cnt % IMG) == 4) ? 11'd100 : 11'd0)) bad++;
        cnt++;
      end else if (cnt > 0 && bus.ir_addr !== IR_ADDR_W'(cnt - 1)) begin
        bad++;
      end
    end
    bus.ir_enable = 1'b0;
    chk("t5_count", cnt, NPIX);
    chk("t5_toggle_seq", bad, 0);
    step();
    chk("t5_ir_done", bus.ir_done, 1);

    // sinogram value = its address; pixels hand-computed from the bin formula
    for (int a = 0; a < (1 << SG_ADDR_W); a++) mem[a] = DATA_W'(a);
    run_bp(1'b0, lat);
    chk("t2b_latency", lat, LAT);
    read_image();
    chk("t2b_pix_0_0", rd[0], 488);
    chk("t2b_pix_7_0", rd[7], 494);
    chk("t2b_pix_4_4", rd[36], 512);

    // reset in the middle of a backprojection
    bus.sg_kick = 1'b1;
    step();
    bus.sg_kick = 1'b0;
    repeat (300) step();
    reset_n = 1'b1;
    #1;
    chk("t6_rst_sg_addr", bus.sg_addr, 0);
    chk("t6_rst_sg_done", bus.sg_done, 0);
    chk("t6_rst_ir_addr", bus.ir_addr, 0);
    chk("t6_rst_ir_val", bus.ir_val, 0);
    step();
    reset_n = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.sg_done === 1'b1) pulses++;
    end
    chk("t6_no_sg_done", pulses, 0);
    run_bp(1'b0, lat);
    chk("t6_latency", lat, LAT);
    read_image();
    chk("t6_pix_0_0", rd[0], 488);
    chk("t6_pix_4_4", rd[36], 512);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
